noc_packet_injector: RTL and testbench
======================================

// Module: noc_packet_injector
// PURPOSE
//  Local-port transmitter for the dual-parallel mesh router: converts a raw beat stream plus a
//  destination (x,y) into one or more NoC packets (header flit + payload flits, TLAST on last).
//  Store-and-forward: beats are buffered so the header carries the exact payload count.
//  Output drives the router's local input channel (req or resp; one instance per channel).
// PARAMETERS
//  DATA_WIDTH     32  flit/beat tdata width
//  MAX_ROUTERS_X  4   mesh width;  XW = $clog2(MAX_ROUTERS_X)
//  MAX_ROUTERS_Y  4   mesh height; YW = $clog2(MAX_ROUTERS_Y)
//  ROUTER_X       0   x coordinate of the attached router (source field)
//  ROUTER_Y       0   y coordinate of the attached router (source field)
//  MAX_PACKAGES   4   max payload beats per packet; CW = $clog2(MAX_PACKAGES+1)
// PORTS
//  clk_i        in   1           clock
//  rst_n_i      in   1           synchronous reset, active low
//  s_valid_i    in   1           payload beat valid
//  s_ready_o    out  1           payload beat accepted when s_valid_i & s_ready_o
//  s_data_i     in   DATA_WIDTH  payload beat
//  s_last_i     in   1           last beat of the upstream message
//  dest_x_i     in   XW          destination x, sampled with the first beat of a packet
//  dest_y_i     in   YW          destination y, sampled with the first beat of a packet
//  out_mosi_o   out  axis_mosi_t flit stream to router (tvalid, tdata, tlast used)
//  out_miso_i   in   axis_miso_t tready from router
// BEHAVIOUR
//  Connection: single clock domain, synchronous active-low reset on clk_i/rst_n_i.
//  Header flit tdata: [XW-1:0]=dest_x, [XW+:YW]=dest_y, next XW=ROUTER_X, next YW=ROUTER_Y,
//   next CW=payload count (1..MAX_PACKAGES); remaining bits 0. Elaboration error if
//   DATA_WIDTH < 2*XW+2*YW+CW. Header tlast=0; last payload flit tlast=1.
//  FSM IDLE -> FILL -> HEADER -> DATA -> IDLE:
//   IDLE:   s_ready_o=1; first accepted beat writes buf[0], latches dest, cnt=1, -> FILL;
//           if that beat has s_last_i or MAX_PACKAGES==1 -> HEADER directly.
//   FILL:   s_ready_o=1; each accepted beat writes buf[cnt], cnt++; -> HEADER when accepted
//           beat has s_last_i or cnt reaches MAX_PACKAGES.
//   HEADER: s_ready_o=0; tvalid=1 with header; on tready -> DATA, rd=0.
//   DATA:   s_ready_o=0; tvalid=1, tdata=buf[rd], tlast=(rd==cnt-1); on tready rd++;
//           on accepted tlast flit -> IDLE.
//  Splitting: message longer than MAX_PACKAGES beats is split into packets of MAX_PACKAGES;
//   s_last_i is not forwarded per se -- each packet ends with its own tlast. Remaining beats
//   form a new packet; dest re-sampled from dest_x_i/dest_y_i on its first beat.
//  Handshake: tvalid never deasserts and tdata/tlast never change until tready seen.
//   No combinational path tready -> s_ready_o or s_valid_i -> tvalid.
//  Latency: first header flit valid 1 cycle after last buffered beat accepted; min packet
//   period = 2*cnt+1 cycles (cnt fill, 1 header, cnt data) with no backpressure.
//  Reset values: out tvalid=0, tlast=0, tdata=0, s_ready_o=0 during reset, 1 after (IDLE);
//   cnt=0, rd=0, state=IDLE.
//  Reset mid-operation: buffered/partially sent packet discarded, tvalid=0 next cycle;
//   no truncated tlast emitted.
//  Stalls: tready low indefinitely holds HEADER/DATA state; s_valid_i gaps in FILL allowed.
// TESTING
//  4x4 mesh, ROUTER=(0,0), DW=32, MAX_PACKAGES=4 unless stated.
//  3 beats A,B,C (C last), dest (2,1), tready=1 -> flits 0x306, A, B, C(tlast); s_ready_o low 4 cycles.
//  1 beat D last, dest (3,3) -> flits 0x10F, D(tlast); header appears cycle after D accepted.
//  6-beat message dest (1,2) -> packets 0x409+4 beats(tlast), then 0x209+2 beats(tlast).
//  tready toggled randomly over 3-beat packet -> tdata/tlast stable while tvalid&!tready; order kept.
//  rst_n_i low 1 cycle during DATA rd=1 -> tvalid=0 next cycle, no tlast; next message sent intact.
//  ROUTER=(1,2), 2 beats dest (0,0) -> header 0x290 ([7:4]=src 1|2<<2, [10:8]=2).

Source files
------------

// File: rtl/noc_axis_pkg.sv
// Flit-stream types shared between the packet injector and the mesh router local port.
package noc_axis_pkg;

  localparam int unsigned NOC_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      tvalid;
    logic [NOC_DATA_WIDTH-1:0] tdata;
    logic                      tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

endpackage

// File: rtl/noc_packet_injector.sv
// Store-and-forward local-port transmitter: buffers up to MAX_PACKAGES beats, then emits
// one header flit carrying dest/source/count followed by the buffered payload flits.
module noc_packet_injector
  import noc_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_ROUTERS_X = 4,
  parameter int unsigned MAX_ROUTERS_Y = 4,
  parameter int unsigned ROUTER_X      = 0,
  parameter int unsigned ROUTER_Y      = 0,
  parameter int unsigned MAX_PACKAGES  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  s_valid_i,
  output logic                                  s_ready_o,
  input  logic [DATA_WIDTH-1:0]                 s_data_i,
  input  logic                                  s_last_i,
  input  logic [$clog2(MAX_ROUTERS_X)-1:0]      dest_x_i,
  input  logic [$clog2(MAX_ROUTERS_Y)-1:0]      dest_y_i,
  output axis_mosi_t                            out_mosi_o,
  input  axis_miso_t                            out_miso_i
);

  localparam int unsigned XW = $clog2(MAX_ROUTERS_X);
  localparam int unsigned YW = $clog2(MAX_ROUTERS_Y);
  localparam int unsigned CW = $clog2(MAX_PACKAGES + 1);
  localparam int unsigned IW = (MAX_PACKAGES > 1) ? $clog2(MAX_PACKAGES) : 1;

  generate
    if (DATA_WIDTH < 2 * XW + 2 * YW + CW) begin : g_width_check
      $error("noc_packet_injector: DATA_WIDTH too small for header fields");
    end
    if (DATA_WIDTH != NOC_DATA_WIDTH) begin : g_bus_check
      $error("noc_packet_injector: DATA_WIDTH must match the flit bus width");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HEADER = 2'd2,
    ST_DATA   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         rd_q, rd_d;
  logic [XW-1:0]         dest_x_q, dest_x_d;
  logic [YW-1:0]         dest_y_q, dest_y_d;
  logic [DATA_WIDTH-1:0] buf_q [MAX_PACKAGES];
  logic [DATA_WIDTH-1:0] buf_d [MAX_PACKAGES];
  logic                  s_ready_q, s_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  beat_acc;
  logic                  flit_acc;

  function automatic logic [DATA_WIDTH-1:0] build_header(
    input logic [XW-1:0] dx,
    input logic [YW-1:0] dy,
    input logic [CW-1:0] cnt
  );
    logic [DATA_WIDTH-1:0] h;
    h                        = '0;
    h[0 +: XW]               = dx;
    h[XW +: YW]              = dy;
    h[XW + YW +: XW]         = XW'(ROUTER_X);
    h[2 * XW + YW +: YW]     = YW'(ROUTER_Y);
    h[2 * XW + 2 * YW +: CW] = cnt;
    return h;
  endfunction

  assign beat_acc = s_valid_i & s_ready_q;
  assign flit_acc = out_valid_q & out_miso_i.tready;

  // Next-state logic; output flops are loaded from the next state so the header
  // is valid the cycle after the final buffered beat is accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    dest_x_d    = dest_x_q;
    dest_y_d    = dest_y_q;
    buf_d       = buf_q;
    s_ready_d   = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          buf_d[0] = s_data_i;
          dest_x_d = dest_x_i;
          dest_y_d = dest_y_i;
          cnt_d    = CW'(1);
          state_d  = (s_last_i || (MAX_PACKAGES == 1)) ? ST_HEADER : ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (beat_acc) begin
          buf_d[cnt_q[IW-1:0]] = s_data_i;
          cnt_d                = cnt_q + CW'(1);
          if (s_last_i || (cnt_d == CW'(MAX_PACKAGES))) begin
            state_d = ST_HEADER;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_HEADER: begin
        if (flit_acc) begin
          state_d = ST_DATA;
          rd_d    = '0;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_DATA: begin
        if (flit_acc && out_last_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rd_d    = '0;
        end else if (flit_acc) begin
          rd_d = rd_q + IW'(1);
        end else begin
          rd_d = rd_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rd_d    = '0;
      end
    endcase

    case (state_d)
      ST_IDLE, ST_FILL: begin
        s_ready_d = 1'b1;
      end
      ST_HEADER: begin
        out_valid_d = 1'b1;
        out_data_d  = build_header(dest_x_d, dest_y_d, cnt_d);
      end
      ST_DATA: begin
        out_valid_d = 1'b1;
        out_data_d  = buf_d[rd_d];
        out_last_d  = (CW'(rd_d) == (cnt_d - CW'(1)));
      end
      default: begin
        s_ready_d = 1'b0;
      end
    endcase
  end

  // State, buffer and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      dest_x_q    <= '0;
      dest_y_q    <= '0;
      buf_q       <= '{default: '0};
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      dest_x_q    <= dest_x_d;
      dest_y_q    <= dest_y_d;
      buf_q       <= buf_d;
      s_ready_q   <= s_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign s_ready_o         = s_ready_q;
  assign out_mosi_o.tvalid = out_valid_q;
  assign out_mosi_o.tdata  = out_data_q;
  assign out_mosi_o.tlast  = out_last_q;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: a per-cycle vector table plus hand-written
// sequences for backpressure, mid-packet reset and a non-origin source router.
module tb_noc_packet_injector;
  import noc_axis_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [1:0]  dest_x, dest_y;
  axis_mosi_t  mosi;
  axis_miso_t  miso;

  logic        b_valid, b_ready, b_last;
  logic [31:0] b_data;
  logic [1:0]  b_dx, b_dy;
  axis_mosi_t  b_mosi;
  axis_miso_t  b_miso;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noc_packet_injector #(
    .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(0), .ROUTER_Y(0), .MAX_PACKAGES(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_last_i(s_last), .dest_x_i(dest_x), .dest_y_i(dest_y),
    .out_mosi_o(mosi), .out_miso_i(miso)
  );

  noc_packet_injector #(
    .DATA_WIDTH(32), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
    .ROUTER_X(1), .ROUTER_Y(2), .MAX_PACKAGES(4)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(b_valid), .s_ready_o(b_ready),
    .s_data_i(b_data), .s_last_i(b_last), .dest_x_i(b_dx), .dest_y_i(b_dy),
    .out_mosi_o(b_mosi), .out_miso_i(b_miso)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic        e_srdy;
    logic        e_tv;
    logic [31:0] e_td;
    logic        e_tl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic l,
                              input logic [1:0] dx, input logic [1:0] dy,
                              input logic e_srdy, input logic e_tv,
                              input logic [31:0] e_td, input logic e_tl);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.dx = dx; r.dy = dy;
    r.e_srdy = e_srdy; r.e_tv = e_tv; r.e_td = e_td; r.e_tl = e_tl;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  localparam logic [31:0] A  = 32'hA000_0001, B  = 32'hB000_0002, C  = 32'hC000_0003;
  localparam logic [31:0] D  = 32'hD000_0004;
  localparam logic [31:0] M0 = 32'h1000_0000, M1 = 32'h1000_0001, M2 = 32'h1000_0002;
  localparam logic [31:0] M3 = 32'h1000_0003, M4 = 32'h1000_0004, M5 = 32'h1000_0005;

  logic [31:0] rexp [4];
  logic        rlast [4];
  int          idx;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; dest_x = '0; dest_y = '0;
    miso.tready = 1'b1;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_dx = '0; b_dy = '0; b_miso.tready = 1'b1;

    // 3 beats dest (2,1); dest changes on later beats must be ignored
    vq.push_back(mk(1'b1, A, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, B, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, C, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 32'h306, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, A, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, B, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, C, 1'b1));
    // single beat dest (3,3)
    vq.push_back(mk(1'b1, D, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 32'h10F, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, D, 1'b1));
    // 6-beat message dest (1,2), with a gap in FILL and M4 held while not ready
    vq.push_back(mk(1'b1, M0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, M1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, M2, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, M2, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, M3, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 32'h409, 1'b0));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, M0, 1'b0));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, M1, 1'b0));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, M2, 1'b0));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, M3, 1'b1));
    vq.push_back(mk(1'b1, M4, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b1, M5, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 32'h209, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, M4, 1'b0));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, M5, 1'b1));
    vq.push_back(mk(1'b0, 32'h0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0, 1'b0));

    // reset state
    repeat (3) @(negedge clk);
    check("rst tvalid", {31'b0, mosi.tvalid}, 32'h0);
    check("rst tlast", {31'b0, mosi.tlast}, 32'h0);
    check("rst tdata", mosi.tdata, 32'h0);
    check("rst s_ready", {31'b0, s_ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst s_ready", {31'b0, s_ready}, 32'h1);

    foreach (vq[i]) begin
      @(negedge clk);
      s_valid = vq[i].v; s_data = vq[i].d; s_last = vq[i].l;
      dest_x = vq[i].dx; dest_y = vq[i].dy;
      check($sformatf("vec%0d s_ready", i), {31'b0, s_ready}, {31'b0, vq[i].e_srdy});
      check($sformatf("vec%0d tvalid", i), {31'b0, mosi.tvalid}, {31'b0, vq[i].e_tv});
      if (vq[i].e_tv) begin
        check($sformatf("vec%0d tdata", i), mosi.tdata, vq[i].e_td);
        check($sformatf("vec%0d tlast", i), {31'b0, mosi.tlast}, {31'b0, vq[i].e_tl});
      end
    end

    // random backpressure over a 3-beat packet dest (1,1)
    rexp[0] = 32'h305; rexp[1] = 32'hE000_0000; rexp[2] = 32'hE000_0001; rexp[3] = 32'hE000_0002;
    rlast[0] = 1'b0; rlast[1] = 1'b0; rlast[2] = 1'b0; rlast[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = rexp[k+1]; s_last = (k == 2); dest_x = 2'd1; dest_y = 2'd1;
    end
    idx = 0;
    for (int k = 0; k < 200 && idx < 4; k++) begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      check($sformatf("bp%0d tvalid", k), {31'b0, mosi.tvalid}, 32'h1);
      check($sformatf("bp%0d tdata", k), mosi.tdata, rexp[idx]);
      check($sformatf("bp%0d tlast", k), {31'b0, mosi.tlast}, {31'b0, rlast[idx]});
      miso.tready = 1'($urandom_range(0, 1));
      if (miso.tready) idx++;
    end
    check("bp completed", idx, 4);
    @(negedge clk);
    miso.tready = 1'b1;
    check("bp end tvalid", {31'b0, mosi.tvalid}, 32'h0);
    check("bp end s_ready", {31'b0, s_ready}, 32'h1);

    // reset while the second payload flit (rd=1) is on the bus
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'hF000_0000 + k; s_last = (k == 2); dest_x = 2'd3; dest_y = 2'd0;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("mr header", mosi.tdata, 32'h303);
    @(negedge clk);
    check("mr flit0", mosi.tdata, 32'hF000_0000);
    @(negedge clk);
    check("mr flit1", mosi.tdata, 32'hF000_0001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr tvalid after rst", {31'b0, mosi.tvalid}, 32'h0);
    check("mr tlast after rst", {31'b0, mosi.tlast}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("mr idle%0d tvalid", k), {31'b0, mosi.tvalid}, 32'h0);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("mr z%0d s_ready", k), {31'b0, s_ready}, 32'h1);
      s_valid = 1'b1; s_data = 32'h2200_0000 + k; s_last = (k == 1); dest_x = 2'd2; dest_y = 2'd2;
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("mr z header", mosi.tdata, 32'h20A);
    check("mr z header tvalid", {31'b0, mosi.tvalid}, 32'h1);
    @(negedge clk);
    check("mr z0", mosi.tdata, 32'h2200_0000);
    check("mr z0 tlast", {31'b0, mosi.tlast}, 32'h0);
    @(negedge clk);
    check("mr z1", mosi.tdata, 32'h2200_0001);
    check("mr z1 tlast", {31'b0, mosi.tlast}, 32'h1);
    @(negedge clk);
    check("mr z done", {31'b0, mosi.tvalid}, 32'h0);

    // source router (1,2), 2 beats to (0,0)
    @(negedge clk);
    b_valid = 1'b1; b_data = 32'h5A5A_0000; b_last = 1'b0; b_dx = 2'd0; b_dy = 2'd0;
    @(negedge clk);
    b_data = 32'h5A5A_0001; b_last = 1'b1;
    @(negedge clk);
    b_valid = 1'b0; b_last = 1'b0;
    check("src hdr tvalid", {31'b0, b_mosi.tvalid}, 32'h1);
    check("src hdr", b_mosi.tdata, 32'h290);
    @(negedge clk);
    check("src p0", b_mosi.tdata, 32'h5A5A_0000);
    @(negedge clk);
    check("src p1", b_mosi.tdata, 32'h5A5A_0001);
    check("src p1 tlast", {31'b0, b_mosi.tlast}, 32'h1);
    @(negedge clk);
    check("src done", {31'b0, b_mosi.tvalid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
